// File: rtl/seq_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_loader_if
// Description : Bundles the word stream, the layer data/launch/done bus and
//               the result handshake of the sequential-layer loader.
//               slave  = loader side, master = environment side.
// Revision    : 1.0  initial release
// ============================================================================
interface seq_loader_if #(
    parameter int N = 4,
    parameter int B = 4,
    parameter int M = 4
) ();
    // Input word stream
    logic           s_valid;
    logic           s_ready;
    logic [B-1:0]   s_data;
    // Layer bus
    logic [N*B-1:0] layer_data;
    logic           layer_rst;
    logic           layer_done;
    logic [M-1:0]   layer_out;
    // Result handshake
    logic           res_valid;
    logic           res_ready;
    logic [M-1:0]   res_data;

    modport slave (
        input  s_valid, s_data, layer_done, layer_out, res_ready,
        output s_ready, layer_data, layer_rst, res_valid, res_data
    );

    modport master (
        output s_valid, s_data, layer_done, layer_out, res_ready,
        input  s_ready, layer_data, layer_rst, res_valid, res_data
    );
endinterface
`default_nettype wire

// File: rtl/seq_loader.sv
`default_nettype none
// ============================================================================
// Module      : seq_loader
// Description : Producer/consumer wrapper around one cnt-driven sequential
//               BNN layer. Collects N words of B bits into a load buffer,
//               moves a full buffer to a stable active register, launches
//               the layer with a one-cycle reset pulse and captures its
//               M-bit sign output into a valid/ready result slot. The next
//               frame loads while the current one computes.
// Revision    : 1.0  initial release
// ============================================================================
module seq_loader #(
    parameter int N = 4,
    parameter int B = 4,
    parameter int M = 4
) (
    input  logic              clk,
    input  logic              rst,
    seq_loader_if.slave       bus
);

    localparam int             WCW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [WCW-1:0] LAST = WCW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           buf_full_q, buf_full_d;
    logic [N*B-1:0] buf_q, buf_d;
    logic [N*B-1:0] ldata_q, ldata_d;
    logic [M-1:0]   res_data_q, res_data_d;
    logic           res_valid_q, res_valid_d;
    logic           rdy_en_q;

    logic           w_xfer;
    logic           w_launch;

    // Ready is held low through reset and for the first edge after it.
    assign bus.s_ready    = rdy_en_q && !buf_full_q;
    assign bus.layer_rst  = (state_q == ST_LAUNCH);
    assign bus.layer_data = ldata_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;

    assign w_xfer = bus.s_valid && rdy_en_q && !buf_full_q;

    // Load side: write the word at slot wcnt, flag the buffer full on the last slot.
    always_comb begin
        buf_d      = buf_q;
        wcnt_d     = wcnt_q;
        buf_full_d = buf_full_q;
        if (w_xfer) begin
            for (int i = 0; i < N; i++) begin
                if (wcnt_q == WCW'(i)) begin
                    buf_d[i*B +: B] = bus.s_data;
                end
            end
            if (wcnt_q == LAST) begin
                wcnt_d     = '0;
                buf_full_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + WCW'(1);
            end
        end
        // A transfer and a launch can never coincide: one needs the buffer
        // empty, the other needs it full.
        if (w_launch) begin
            buf_full_d = 1'b0;
        end
    end

    // Compute FSM next state, active-frame copy and result slot update.
    always_comb begin
        state_d     = state_q;
        ldata_d     = ldata_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        w_launch    = 1'b0;

        if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // The result slot counts as free if it is consumed this edge.
                if (buf_full_q && (!res_valid_q || bus.res_ready)) begin
                    w_launch = 1'b1;
                    ldata_d  = buf_q;
                    state_d  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.layer_done) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // One cycle after done so the layer accumulators have settled.
                res_data_d  = bus.layer_out;
                res_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Load-side registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q      <= '0;
            wcnt_q     <= '0;
            buf_full_q <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            wcnt_q     <= wcnt_d;
            buf_full_q <= buf_full_d;
            rdy_en_q   <= 1'b1;
        end
    end

    // FSM state, active frame and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ldata_q     <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ldata_q     <= ldata_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_loader
// Description : Directed self-checking bench for seq_loader with a stub of
//               the cnt-driven sequential layer (N=4, B=4, M=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_loader;

    localparam int N = 4;
    localparam int B = 4;
    localparam int M = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_loader_if #(.N(N), .B(B), .M(M)) bus ();

    seq_loader #(.N(N), .B(B), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- Layer stub: counter restarts on layer_rst, done at N-1,
    // output settles one cycle after done (XOR of the four words).
    logic [1:0] lc_q;
    logic       lrun_q;
    logic [3:0] lout_q;
    logic       force_launch_done = 1'b0;

    function automatic logic [3:0] fold(input logic [15:0] d);
        return d[3:0] ^ d[7:4] ^ d[11:8] ^ d[15:12];
    endfunction

    assign bus.layer_done = (lrun_q && (lc_q == 2'(N - 1)) && !bus.layer_rst) ||
                            (force_launch_done && bus.layer_rst);
    assign bus.layer_out  = lout_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lc_q   <= 2'd0;
            lrun_q <= 1'b0;
            lout_q <= 4'd0;
        end else if (bus.layer_rst) begin
            lc_q   <= 2'd0;
            lrun_q <= 1'b1;
            lout_q <= 4'd0;
        end else begin
            if (lrun_q && (lc_q != 2'(N - 1))) lc_q <= lc_q + 2'd1;
            if (bus.layer_done) lout_q <= fold(bus.layer_data);
        end
    end

    // ---------------- Monitor (samples pre-edge values at each rising edge)
    int          edge_n = 0, xfer_n = 0, last_xfer_e = 0;
    int          pulse_n = 0, rv_n = 0, take_n = 0, take_e = 0, wide_n = 0;
    int          pulse_e_q[$];
    int          rv_e_q[$];
    logic [15:0] exp_ld_q[$];
    logic [3:0]  exp_res_q[$];
    logic [15:0] held_ld = 16'h0;
    logic        lr_prev = 1'b0, rv_prev = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            if (bus.s_valid && bus.s_ready) begin
                xfer_n++;
                last_xfer_e = edge_n;
            end
            if (bus.layer_rst) begin
                if (lr_prev) wide_n++;
                pulse_n++;
                pulse_e_q.push_back(edge_n);
                held_ld = bus.layer_data;
                check_val("launch_expected", 32'(exp_ld_q.size() > 0), 1);
                if (exp_ld_q.size() > 0)
                    check_val("layer_data", bus.layer_data, exp_ld_q.pop_front());
            end
            if (bus.res_valid && !rv_prev) begin
                rv_n++;
                rv_e_q.push_back(edge_n);
                check_val("rv_latency", edge_n - pulse_e_q[$], N + 2);
                check_val("ld_stable", bus.layer_data, held_ld);
            end
            if (bus.res_valid && bus.res_ready) begin
                take_n++;
                take_e = edge_n;
                check_val("result_expected", 32'(exp_res_q.size() > 0), 1);
                if (exp_res_q.size() > 0)
                    check_val("res_data", bus.res_data, exp_res_q.pop_front());
            end
            lr_prev = bus.layer_rst;
            rv_prev = bus.res_valid;
        end
    end

    // ---------------- Driver helpers (called at a falling edge)
    task automatic send_word(input logic [3:0] w);
        int t = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        while (!bus.s_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_val("send_accept", bus.s_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = ~w;   // junk while not valid
    endtask

    task automatic send_frame(input logic [15:0] d);
        for (int i = 0; i < 4; i++) send_word(d[i*4 +: 4]);
    endtask

    task automatic expect_frame(input logic [15:0] d, input logic [3:0] r, input bit keep);
        exp_ld_q.push_back(d);
        if (keep) exp_res_q.push_back(r);
    endtask

    function automatic int ev_count(input int sel);
        case (sel)
            0:       return pulse_n;
            1:       return rv_n;
            2:       return take_n;
            default: return xfer_n;
        endcase
    endfunction

    task automatic wait_ev(input int sel, input int target, input string tag);
        int t = 0;
        while (ev_count(sel) < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_val(tag, 32'(ev_count(sel) >= target), 1);
    endtask

    // ---------------- Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- Directed sequence
    initial begin
        int base;
        bus.s_valid   = 1'b0;
        bus.s_data    = 4'h0;
        bus.res_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_s_ready",    bus.s_ready,    0);
        check_val("rst_layer_rst",  bus.layer_rst,  0);
        check_val("rst_layer_data", bus.layer_data, 0);
        check_val("rst_res_valid",  bus.res_valid,  0);
        check_val("rst_res_data",   bus.res_data,   0);
        rst = 1'b0;
        #1;
        check_val("s_ready_pre_edge", bus.s_ready, 0);
        @(negedge clk);
        check_val("s_ready_post_edge", bus.s_ready, 1);

        // 1: single frame, back-to-back words
        bus.res_ready = 1'b1;
        expect_frame(16'h4321, 4'h4, 1'b1);
        send_frame(16'h4321);
        wait_ev(0, 1, "t1_pulse");
        check_val("t1_xfer_to_pulse", pulse_e_q[$] - last_xfer_e, 2);
        wait_ev(2, 1, "t1_take");
        check_val("t1_rv_dropped", bus.res_valid, 0);

        // 2: result back-pressure over three frames
        bus.res_ready = 1'b0;
        expect_frame(16'h8765, 4'hC, 1'b1);
        expect_frame(16'hCBA9, 4'h4, 1'b1);
        expect_frame(16'h0FED, 4'hC, 1'b1);
        send_frame(16'h8765);
        send_frame(16'hCBA9);
        wait_ev(1, 2, "t2_rv_a");
        repeat (10) @(negedge clk);
        check_val("t2_no_launch",  pulse_n,       2);
        check_val("t2_s_ready",    bus.s_ready,   0);
        check_val("t2_res_held",   bus.res_data,  4'hC);
        check_val("t2_rv_held",    bus.res_valid, 1);
        base = xfer_n;
        fork
            send_frame(16'h0FED);
        join_none
        repeat (5) @(negedge clk);
        check_val("t2_stalled", xfer_n - base, 0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        wait_ev(0, 3, "t2_pulse_b");
        check_val("t2_launch_on_take", pulse_e_q[2] - take_e, 1);
        wait_ev(1, 3, "t2_rv_b");
        repeat (10) @(negedge clk);
        check_val("t2_no_launch_c", pulse_n,      3);
        check_val("t2_res_b_held",  bus.res_data, 4'h4);
        check_val("t2_c_loaded",    xfer_n - base, 4);
        bus.res_ready = 1'b1;
        wait_ev(2, 4, "t2_take_c");

        // 3: overlap, frame 2 loads during frame 1 run
        base = pulse_n;
        expect_frame(16'h7531, 4'h0, 1'b1);
        expect_frame(16'hF842, 4'h1, 1'b1);
        send_frame(16'h7531);
        send_frame(16'hF842);
        wait_ev(2, 6, "t3_take");
        check_val("t3_no_gap", pulse_e_q[base + 1] - rv_e_q[base], 1);

        // 4: gapped input, s_valid 1,0,1,0
        base = xfer_n;
        expect_frame(16'hC51A, 4'h2, 1'b1);
        send_word(4'hA); @(negedge clk);
        send_word(4'h1); @(negedge clk);
        send_word(4'h5); @(negedge clk);
        send_word(4'hC);
        wait_ev(0, 7, "t4_pulse");
        check_val("t4_xfers", xfer_n - base, 4);
        check_val("t4_xfer_to_pulse", pulse_e_q[$] - last_xfer_e, 2);
        wait_ev(2, 7, "t4_take");

        // 5: async reset with a held result and a half-filled buffer
        bus.res_ready = 1'b0;
        expect_frame(16'h2311, 4'h1, 1'b0);
        send_frame(16'h2311);
        wait_ev(1, 8, "t5_rv");
        send_word(4'h3);
        send_word(4'h9);
        check_val("t5_pre_s_ready",  bus.s_ready,   1);
        check_val("t5_pre_rv",       bus.res_valid, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_val("t5_s_ready",    bus.s_ready,    0);
        check_val("t5_res_valid",  bus.res_valid,  0);
        check_val("t5_layer_rst",  bus.layer_rst,  0);
        check_val("t5_res_data",   bus.res_data,   0);
        check_val("t5_layer_data", bus.layer_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.res_ready = 1'b1;
        base = xfer_n;
        expect_frame(16'hB876, 4'h2, 1'b1);
        send_frame(16'hB876);
        wait_ev(0, 9, "t5_pulse");
        check_val("t5_clean_frame", xfer_n - base, 4);
        wait_ev(2, 8, "t5_take");

        // 6: done forced high during LAUNCH must not be captured
        force_launch_done = 1'b1;
        expect_frame(16'h8421, 4'hF, 1'b1);
        send_frame(16'h8421);
        wait_ev(2, 9, "t6_take");
        force_launch_done = 1'b0;

        repeat (4) @(negedge clk);
        check_val("single_cycle_pulse", wide_n, 0);
        check_val("results_drained", exp_res_q.size(), 0);
        check_val("launches_drained", exp_ld_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
